// File: rtl/rf_wb_ctrl.sv
// -----------------------------------------------------------------------------
// rf_wb_ctrl
//   Write-side initiator for the 8x16b register file. Right after reset it walks
//   every RF address writing zero (INIT). It then enters RUN, where it buffers
//   datapath writeback results in a small FIFO and drains one entry per cycle
//   onto the RF write port.
//
// Configuration macro:
//   RF_WB_FWD_EN  when defined, operand reads are forwarded from the newest
//                 pending FIFO entry that targets the same register, so the
//                 datapath never sees stale RF data. When undefined, operands
//                 come straight from the RF and the caller must wait for
//                 wb_empty before reading a register with a pending write.
//
// Parameters:
//   DEPTH  FIFO entries (power of 2, >= 2)
//   AW     register address width (2**AW registers)
//   DW     data width
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   wb_valid/ready    writeback request handshake
//   wb_addr, wb_data  writeback destination and data
//   rd_addr0/1        operand register numbers (also drive RF read addresses)
//   rf_data0/1        RF read data
//   op_data0/1        operands to the datapath
//   RegWrite          RF write enable
//   write_register    RF write address
//   write_data        RF write data
//   init_done         high once the RF clear sequence has finished
//   wb_empty          FIFO empty, every accepted write has been committed
//
// Handshake: a writeback is transferred at a rising clk edge where
//   wb_valid && wb_ready. wb_ready depends only on internal state, never on
//   wb_valid. While wb_valid is high and wb_ready low, the caller holds
//   wb_addr/wb_data stable until the transfer happens.
// -----------------------------------------------------------------------------
module rf_wb_ctrl #(
    parameter int DEPTH = 4,
    parameter int AW    = 3,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wb_valid,
    output logic          wb_ready,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    input  logic [AW-1:0] rd_addr0,
    input  logic [AW-1:0] rd_addr1,
    input  logic [DW-1:0] rf_data0,
    input  logic [DW-1:0] rf_data1,
    output logic [DW-1:0] op_data0,
    output logic [DW-1:0] op_data1,
    output logic          RegWrite,
    output logic [AW-1:0] write_register,
    output logic [DW-1:0] write_data,
    output logic          init_done,
    output logic          wb_empty
);

    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;
    localparam int NREG = 2 ** AW;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] idx;
    logic [AW-1:0] idx_nxt;

    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic push;
    logic pop;

    // Full blocks acceptance even when a pop happens in the same cycle.
    assign wb_ready = (state == S_RUN) && (count < CW'(DEPTH));
    assign wb_empty = (count == '0);
    assign push     = wb_valid && wb_ready;
    // The head is on the write port whenever RUN and non-empty, so it
    // commits (and leaves the FIFO) at that edge.
    assign pop      = (state == S_RUN) && !wb_empty;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_INIT;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        idx_nxt        = idx;
        RegWrite       = 1'b0;
        write_register = addr_mem[rd_ptr];
        write_data     = data_mem[rd_ptr];
        init_done      = 1'b0;
        case (state)
            S_INIT: begin
                RegWrite       = 1'b1;
                write_register = idx;
                write_data     = '0;
                idx_nxt        = idx + 1'b1;
                if (idx == AW'(NREG - 1)) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                init_done = 1'b1;
                RegWrite  = !wb_empty;
            end
            default: begin
                state_nxt = S_INIT;
                idx_nxt   = '0;
            end
        endcase
    end

    // ---------------------------------------------------------------- FIFO
    // Storage needs no reset: only entries inside [rd_ptr, rd_ptr+count) are
    // ever observed.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= wb_addr;
            data_mem[wr_ptr] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so natural pointer overflow is the wrap.
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ---------------------------------------------------------------- operands
`ifdef RF_WB_FWD_EN
    // Scan from oldest to newest valid entry; a later match overrides an
    // earlier one, so the most recently accepted write to the register wins.
    // The head is included because it is only committed at the next edge.
    always_comb begin
        op_data0 = rf_data0;
        op_data1 = rf_data1;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count) begin
                if (addr_mem[rd_ptr + PW'(i)] == rd_addr0) begin
                    op_data0 = data_mem[rd_ptr + PW'(i)];
                end
                if (addr_mem[rd_ptr + PW'(i)] == rd_addr1) begin
                    op_data1 = data_mem[rd_ptr + PW'(i)];
                end
            end
        end
    end
`else
    // Operand addresses only steer the RF itself in this build.
    logic unused_rd_addr;
    assign unused_rd_addr = ^{rd_addr0, rd_addr1};
    assign op_data0       = rf_data0;
    assign op_data1       = rf_data1;
`endif

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rf_wb_ctrl
//   Bench for rf_wb_ctrl. Provides a behavioural 8x16 register file, a
//   queue-based reference model of the controller, a per-cycle compare
//   process, and directed scenarios with literal expectations.
// -----------------------------------------------------------------------------
module tb_rf_wb_ctrl;

    localparam int DEPTH = 4;
    localparam int AW    = 3;
    localparam int DW    = 16;
    localparam int NREG  = 8;
    localparam int INIT_CYCLES = 8;

    // ------------------------------------------------------ clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic          wb_valid = 1'b0;
    logic          wb_ready;
    logic [AW-1:0] wb_addr  = '0;
    logic [DW-1:0] wb_data  = '0;
    logic [AW-1:0] rd_addr0 = '0;
    logic [AW-1:0] rd_addr1 = '0;
    logic [DW-1:0] rf_data0;
    logic [DW-1:0] rf_data1;
    logic [DW-1:0] op_data0;
    logic [DW-1:0] op_data1;
    logic          RegWrite;
    logic [AW-1:0] write_register;
    logic [DW-1:0] write_data;
    logic          init_done;
    logic          wb_empty;

    rf_wb_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wb_valid       (wb_valid),
        .wb_ready       (wb_ready),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data),
        .rd_addr0       (rd_addr0),
        .rd_addr1       (rd_addr1),
        .rf_data0       (rf_data0),
        .rf_data1       (rf_data1),
        .op_data0       (op_data0),
        .op_data1       (op_data1),
        .RegWrite       (RegWrite),
        .write_register (write_register),
        .write_data     (write_data),
        .init_done      (init_done),
        .wb_empty       (wb_empty)
    );

    // ------------------------------------------------------ register file
    logic [DW-1:0] rf_mem [NREG];
    assign rf_data0 = rf_mem[rd_addr0];
    assign rf_data1 = rf_mem[rd_addr1];

    always @(posedge clk) begin
        if (RegWrite === 1'b1) rf_mem[write_register] <= write_data;
    end

    // ------------------------------------------------------ scoreboard
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out at %0t", nm, $time);
    endtask

    // ------------------------------------------------------ reference model
    // m_init counts clearing writes done since reset; exp_q holds pending
    // writes {addr,data} in acceptance order; exp_rf is the expected RF.
    int                 m_init = 0;
    logic [AW+DW-1:0]   exp_q[$];
    logic [DW-1:0]      exp_rf [NREG];

    always @(posedge clk or negedge rst_n) begin
        bit               acc;
        logic [AW+DW-1:0] nw;
        if (!rst_n) begin
            exp_q.delete();
            m_init = 0;
        end else if (m_init < INIT_CYCLES) begin
            exp_rf[m_init] = '0;
            m_init++;
        end else begin
            acc = (wb_valid === 1'b1) && (exp_q.size() < DEPTH);
            nw  = {wb_addr, wb_data};
            if (exp_q.size() > 0) begin
                exp_rf[exp_q[0][AW+DW-1:DW]] = exp_q[0][DW-1:0];
                void'(exp_q.pop_front());
            end
            if (acc) exp_q.push_back(nw);
        end
    end

    function automatic logic [DW-1:0] exp_op(input logic [AW-1:0] a);
        logic [DW-1:0] r;
        r = exp_rf[a];
`ifdef RF_WB_FWD_EN
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i][AW+DW-1:DW] == a) r = exp_q[i][DW-1:0];
        end
`endif
        return r;
    endfunction

    // Per-cycle compare, away from the active edge.
    bit chk_en = 1'b1;
    always @(negedge clk) begin
        if (chk_en) begin
            if (m_init < INIT_CYCLES) begin
                chk("RegWrite",       RegWrite,       1);
                chk("write_register", write_register, m_init);
                chk("write_data",     write_data,     0);
                chk("wb_ready",       wb_ready,       0);
                chk("init_done",      init_done,      0);
                chk("wb_empty",       wb_empty,       1);
            end else begin
                chk("init_done", init_done, 1);
                chk("wb_empty",  wb_empty,  exp_q.size() == 0);
                chk("wb_ready",  wb_ready,  exp_q.size() < DEPTH);
                chk("RegWrite",  RegWrite,  exp_q.size() != 0);
                if (exp_q.size() != 0) begin
                    chk("write_register", write_register, exp_q[0][AW+DW-1:DW]);
                    chk("write_data",     write_data,     exp_q[0][DW-1:0]);
                end
                chk("op_data0", op_data0, exp_op(rd_addr0));
                chk("op_data1", op_data1, exp_op(rd_addr1));
            end
        end
    end

    // ------------------------------------------------------ driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d, output int waited);
        bit acc;
        acc      = 1'b0;
        waited   = 0;
        wb_valid = 1'b1;
        wb_addr  = a;
        wb_data  = d;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = wb_ready;
            tick();
            waited++;
        end
        wb_valid = 1'b0;
        if (!acc) timeout("push_accept");
    endtask

    task automatic wait_empty();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            seen = wb_empty;
        end
        tick();
        if (!seen) timeout("wait_empty");
    endtask

    task automatic wait_init(output int cycles);
        bit seen;
        seen   = 1'b0;
        cycles = 0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            cycles++;
            seen = init_done;
        end
        tick();
        if (!seen) timeout("wait_init");
    endtask

    // ------------------------------------------------------ stimulus
    int w;
    int wsum;
    int cyc;

    initial begin
        for (int i = 0; i < NREG; i++) begin
            rf_mem[i] = 16'hC0DE;
            exp_rf[i] = 16'hC0DE;
        end

        // 1: reset 100ns, clear sequence, init_done on the 9th cycle
        #1 rst_n = 1'b0;
        #100;
        tick();
        rst_n = 1'b1;
        wait_init(cyc);
        chk("init_cycles", cyc, 9);
        for (int i = 0; i < NREG; i++) chk("rf_cleared", rf_mem[i], 16'h0000);
        @(negedge clk);
        chk("ready_after_init", wb_ready, 1);
        tick();

        // 2: four back-to-back writes, read back through the RF
        push(3'd3, 16'hAAAA, w);
        push(3'd5, 16'h5555, w);
        push(3'd2, 16'hFFFF, w);
        push(3'd1, 16'hA5A5, w);
        wait_empty();
        rd_addr0 = 3'd3;
        rd_addr1 = 3'd5;
        @(negedge clk);
        chk("rd3", op_data0, 16'hAAAA);
        chk("rd5", op_data1, 16'h5555);
        tick();
        rd_addr0 = 3'd2;
        rd_addr1 = 3'd1;
        @(negedge clk);
        chk("rd2", op_data0, 16'hFFFF);
        chk("rd1", op_data1, 16'hA5A5);
        chk("empty_after", wb_empty, 1);
        tick();

        // 3: five consecutive pushes from empty, each accepted in one cycle
        wsum = 0;
        for (int i = 0; i < 5; i++) begin
            push(AW'(i + 2), DW'(16'h1100 + i), w);
            wsum += w;
        end
        chk("five_push_cycles", wsum, 5);
        wait_empty();

        // 3b: a push raised right at reset release stalls through INIT
        rst_n = 1'b0;
        #20;
        tick();
        rst_n = 1'b1;
        push(3'd7, 16'h7777, w);
        chk("init_stall_cycles", w, 9);
        wait_empty();

        // 4: two writes to reg 4, operand read right after the second accept
        push(3'd4, 16'h1234, w);
        push(3'd4, 16'hBEEF, w);
        rd_addr0 = 3'd4;
        @(negedge clk);
`ifdef RF_WB_FWD_EN
        chk("fwd_newest", op_data0, 16'hBEEF);
`else
        chk("no_fwd_rf", op_data0, 16'h1234);
`endif
        tick();
        wait_empty();
        @(negedge clk);
        chk("reg4_final", op_data0, 16'hBEEF);
        tick();

        // 6: 20 writes (i%8, i) with pointer wrap; last write per address wins
        for (int i = 0; i < 20; i++) push(AW'(i % 8), DW'(i), w);
        wait_empty();
        for (int a = 0; a < NREG; a++) begin
            chk("wrap_rf_lit", rf_mem[a], (a < 4) ? a + 16 : a + 8);
            chk("wrap_rf_model", rf_mem[a], exp_rf[a]);
        end

        // 5: reset with a write still queued; it must never reach the RF
        push(3'd6, 16'hDEAD, w);
        rst_n = 1'b0;
        #1;
        chk("rst_empty",    wb_empty,       1);
        chk("rst_regwrite", RegWrite,       1);
        chk("rst_wreg",     write_register, 0);
        chk("rst_ready",    wb_ready,       0);
        #30;
        tick();
        rst_n = 1'b1;
        wait_init(cyc);
        chk("reinit_cycles", cyc, 9);
        rd_addr0 = 3'd6;
        rd_addr1 = 3'd3;
        @(negedge clk);
        chk("reg6_rezeroed", op_data0, 16'h0000);
        chk("reg3_rezeroed", op_data1, 16'h0000);
        chk("rf6_no_dead",   rf_mem[6], 16'h0000);
        tick();
        tick();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
